// File: rtl/lane_scheduler.sv
// lane_scheduler
//   Game-level sequencer for the car lanes. It sits between the frame-rate game
//   logic and N_LANES car instances. It issues per-lane step pulses at a
//   level-dependent rate and merges the per-lane collision flags. A hit respawns
//   the frog, costs a life and freezes traffic for HIT_FRAMES frames. Reaching
//   home raises the level and re-seeds the lanes.
//
// Ports
//   frame_clk      in   frame-rate clock, rising edge
//   Reset          in   synchronous, active-high
//   Start          in   start a game from IDLE / return to IDLE from OVER
//   Car_Collision  in   per-lane collision flags
//   Frog_Home      in   frog reached the far bank
//   Lane_Step      out  one-frame pulse per lane: advance one step
//   Lane_Reset     out  cars held at their start positions while high
//   Frog_Respawn   out  one-frame pulse: frog back to its start position
//   Hit_Lane       out  lowest collided lane index of the last hit
//   Lives          out  remaining lives
//   Level          out  current level
//   Game_Over      out  high while in OVER
module lane_scheduler #(
   parameter int N_LANES     = 4,
   parameter int BASE_PERIOD = 12,
   parameter int LANE_DELTA  = 3,
   parameter int LEVEL_DELTA = 2,
   parameter int MIN_PERIOD  = 2,
   parameter int MAX_LEVEL   = 7,
   parameter int START_LIVES = 3,
   parameter int HIT_FRAMES  = 30
) (
   input  logic               frame_clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic [N_LANES-1:0] Car_Collision,
   input  logic               Frog_Home,
   output logic [N_LANES-1:0] Lane_Step,
   output logic               Lane_Reset,
   output logic               Frog_Respawn,
   output logic [2:0]         Hit_Lane,
   output logic [1:0]         Lives,
   output logic [2:0]         Level,
   output logic               Game_Over
);

   typedef enum logic [2:0] {S_IDLE, S_PLAY, S_HIT, S_LVLUP, S_OVER} state_t;

   state_t     state;
   logic [7:0] cnt    [N_LANES];
   logic [7:0] period [N_LANES];
   logic [7:0] hit_tmr;

   // Lane period in 8b signed so that a steep level drop cannot wrap around;
   // anything under the floor (including negative) clamps to MIN_PERIOD.
   function automatic logic [7:0] lane_period(input int lane, input logic [2:0] lvl);
      logic signed [7:0] base_s;
      logic signed [7:0] drop_s;
      logic signed [7:0] raw_s;
      base_s = signed'(8'(BASE_PERIOD + lane * LANE_DELTA));
      drop_s = signed'(8'(LEVEL_DELTA)) * signed'({5'd0, lvl});
      raw_s  = base_s - drop_s;
      if (raw_s < signed'(8'(MIN_PERIOD)))
         return 8'(MIN_PERIOD);
      return unsigned'(raw_s);
   endfunction

   // Index of the lowest set collision flag.
   function automatic logic [2:0] lowest_set(input logic [N_LANES-1:0] v);
      logic [2:0] idx;
      idx = '0;
      for (int i = N_LANES - 1; i >= 0; i--)
         if (v[i]) idx = 3'(i);
      return idx;
   endfunction

   function automatic logic [1:0] lives_dec_sat(input logic [1:0] l);
      return (l == 2'd0) ? 2'd0 : l - 2'd1;
   endfunction

   function automatic logic [2:0] level_inc_sat(input logic [2:0] l);
      return (l >= 3'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : l + 3'd1;
   endfunction

   always_comb begin
      for (int i = 0; i < N_LANES; i++)
         period[i] = lane_period(i, Level);
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state        <= S_IDLE;
         Lane_Step    <= '0;
         Lane_Reset   <= 1'b1;
         Frog_Respawn <= 1'b0;
         Hit_Lane     <= '0;
         Lives        <= 2'(START_LIVES);
         Level        <= '0;
         Game_Over    <= 1'b0;
         hit_tmr      <= '0;
         for (int i = 0; i < N_LANES; i++) cnt[i] <= '0;
      end else begin
         // Pulses default low so none lasts beyond one frame.
         Lane_Step    <= '0;
         Frog_Respawn <= 1'b0;
         case (state)
            S_IDLE: begin
               Lane_Reset <= 1'b1;
               for (int i = 0; i < N_LANES; i++) cnt[i] <= '0;
               if (Start) begin
                  state      <= S_PLAY;
                  Lane_Reset <= 1'b0;
               end
            end
            S_PLAY: begin
               // A collision outranks reaching home in the same frame.
               if (|Car_Collision) begin
                  Hit_Lane     <= lowest_set(Car_Collision);
                  Lives        <= lives_dec_sat(Lives);
                  Frog_Respawn <= 1'b1;
                  hit_tmr      <= '0;
                  state        <= S_HIT;
               end else if (Frog_Home) begin
                  Level        <= level_inc_sat(Level);
                  Frog_Respawn <= 1'b1;
                  Lane_Reset   <= 1'b1;
                  for (int i = 0; i < N_LANES; i++) cnt[i] <= '0;
                  state        <= S_LVLUP;
               end else begin
                  for (int i = 0; i < N_LANES; i++) begin
                     if (cnt[i] == period[i] - 8'd1) begin
                        cnt[i]       <= '0;
                        Lane_Step[i] <= 1'b1;
                     end else begin
                        cnt[i] <= cnt[i] + 8'd1;
                     end
                  end
               end
            end
            S_LVLUP: begin
               for (int i = 0; i < N_LANES; i++) cnt[i] <= '0;
               Lane_Reset <= 1'b0;
               state      <= S_PLAY;
            end
            S_HIT: begin
               // Counters stay frozen; the dwell ends after exactly HIT_FRAMES frames.
               if (hit_tmr == 8'(HIT_FRAMES - 1)) begin
                  for (int i = 0; i < N_LANES; i++) cnt[i] <= '0;
                  if (Lives == 2'd0) begin
                     state      <= S_OVER;
                     Game_Over  <= 1'b1;
                     Lane_Reset <= 1'b1;
                  end else begin
                     state <= S_PLAY;
                  end
               end else begin
                  hit_tmr <= hit_tmr + 8'd1;
               end
            end
            S_OVER: begin
               Lane_Reset <= 1'b1;
               if (Start) begin
                  state     <= S_IDLE;
                  Lives     <= 2'(START_LIVES);
                  Level     <= '0;
                  Hit_Lane  <= '0;
                  Game_Over <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
